sb_issue_ctrl: RTL and testbench
================================

// Module: sb_issue_ctrl
// PURPOSE
//  Scoreboard issue controller between the decoder and the functional units (FUs).
//  - Takes one decoded instruction record per cycle and holds it in a one-entry issue register.
//  - Tracks pending destination registers (GPR 0-31, HI/LO = 32) and per-FU occupancy.
//  - Dispatches the held record to its FU once RAW, WAW and structural hazards clear.
//  - FUs: 0=ALU0 1=ALU1 2=BRU 3=LSU 4=HILO 5=ALU2 6=ALU3.
// PARAMETERS
//  NUM_FU   7    number of functional units; valid fu codes are 0..NUM_FU-1
//  INFO_WD  137  width of the decoded instruction record (ID_TO_SB_WD)
//  REG_W    6    register index width (64-entry namespace, 32 = HI/LO)
// PORTS
//  clk          in   1              core clock
//  reset        in   1              asynchronous, active-high reset
//  in_valid     in   1              decoder record valid
//  in_info      in   INFO_WD        record: fu[91:89] reg1[88:83] r1_val[82] reg2[80:75] r2_val[74] reg3[72:67] rf_we[66]
//  in_ready     out  1              controller accepts in_info this cycle
//  flush        in   1              pipeline flush (branch mispredict / exception)
//  fu_busy      in   NUM_FU         FU k cannot accept a new op this cycle
//  issue_valid  out  NUM_FU         one-hot dispatch strobe, index = fu code
//  issue_info   out  INFO_WD        held record, unmodified
//  wb_valid     in   NUM_FU         FU k completes its op this cycle
//  wb_we        in   NUM_FU         FU k writes a register on completion
//  wb_reg       in   NUM_FU*REG_W   destination register of FU k, slice [k*REG_W +: REG_W]
//  stall_cnt    out  32             cycles with a held record that did not issue (saturating)
// BEHAVIOUR
//  Reset values: hold_valid=0, pend[63:0]=0, fu_pend=0, stall_cnt=0.
//  Reset outputs: issue_valid=0, in_ready=1.
//  Issue condition; all terms are evaluated from registered state only, with no same-cycle wb bypass:
//    go = hold_valid & ~flush & fu<NUM_FU & ~fu_busy[fu] & ~fu_pend[fu]
//       & ~(r1_val & pend[reg1]) & ~(r2_val & pend[reg2]) & ~(rf_we & pend[reg3])
//  issue_valid = go ? (1<<fu) : 0. This is combinational, so dispatch happens in the same cycle the condition holds.
//  in_ready = ~flush & (~hold_valid | go). A refill can occur in the same cycle as an issue.
//  Accept (in_valid & in_ready): the holding register loads in_info and hold_valid<=1.
//  Issue without refill: hold_valid<=0.
//  On issue:
//    - fu_pend[fu]<=1 (at most one op in flight per FU).
//    - If rf_we & reg3!=0, then pend[reg3]<=1.
//  On wb_valid[k]:
//    - fu_pend[k]<=0.
//    - If wb_we[k] & wb_reg_k!=0, then pend[wb_reg_k]<=0.
//  Writeback-to-dependent issue latency is exactly 1 cycle.
//  Set/clear of the same pend bit in one cycle cannot occur, because WAW blocks the issue.
//  If it does occur, the set wins; the bench flags it with an assertion.
//  Register 0 is never marked pending; a read of r0 is always ready.
//  Register 32 (HI/LO) is tracked like any GPR; mult/div/mthi/mtlo set it and mfhi/mflo wait on it.
//  Flush cycle behaviour:
//    - hold_valid<=0, no issue, in_ready=0.
//    - pend and fu_pend are NOT cleared; in-flight FUs still write back and clear them.
//    - Writebacks arriving during flush are still processed.
//  A record with fu>=NUM_FU never issues; it is held until flush. This is an illegal input and is asserted in the bench.
//  Reset mid-operation clears all state; later writebacks clear already-clear bits, which is harmless.
//  stall_cnt increments when hold_valid & ~go & ~flush, and saturates at 32'hFFFF_FFFF.
// STRUCTURE
//  sb_pkg holds:
//    - record field offsets: FU_LSB=89, REG1_LSB=83, R1V=82, REG2_LSB=75, R2V=74, REG3_LSB=67, RFWE=66
//    - FU code localparams: FU_ALU0..FU_ALU3, FU_BRU, FU_LSU, FU_HILO
//    - REG_HILO=32
//  Sub-module sb_busy_table:
//    - 64-bit pend vector.
//    - One set port (issue) and NUM_FU clear ports (wb).
//    - Three combinational read ports (reg1, reg2, reg3).
//  The top level holds the holding register, fu_pend, the issue logic and the counter.
// TESTING
//  1 Reset asserted mid-run -> next cycle in_ready=1, issue_valid=0, pend=0, fu_pend=0, stall_cnt=0.
//  2 RAW: addu r3 (fu0) issues at T; then or r5,r3,r4 (fu1)
//      -> held, stall_cnt counts.
//      -> wb_valid[0]=1, wb_we[0]=1, wb_reg=3 at cycle N gives issue_valid=7'b0000010 at N+1.
//  3 Structural: lw r2 issues on fu3; then lw r6 (fu3)
//      -> waits for wb_valid[3].
//      -> with fu_busy[3]=1 also held, it issues the first cycle fu_busy[3]=0 after the wb.
//  4 HI/LO: mult (reg3=32, fu4), then mfhi r7 (reg2=32)
//      -> mfhi held until wb_valid[4] with wb_reg=32; issues next cycle on fu4.
//  5 Flush with a blocked held record and pend[3]=1
//      -> hold_valid=0 next cycle, pend[3] stays 1.
//      -> later wb_reg=3 clears it; a new reader of r3 then issues with no stall.
//  6 addu r0,... then addu r1,r0,r0
//      -> the second issues the cycle after the first (r0 never pending), back-to-back refill with in_ready=1.

Source files
------------

// File: rtl/sb_pkg.sv
// Scoreboard issue controller shared definitions.
// Record field offsets, FU codes and register namespace constants.
package sb_pkg;

  localparam int FU_W     = 3;
  localparam int RIDX_W   = 6;

  localparam int FU_LSB   = 89;
  localparam int REG1_LSB = 83;
  localparam int R1V      = 82;
  localparam int REG2_LSB = 75;
  localparam int R2V      = 74;
  localparam int REG3_LSB = 67;
  localparam int RFWE     = 66;

  localparam int FU_ALU0  = 0;
  localparam int FU_ALU1  = 1;
  localparam int FU_BRU   = 2;
  localparam int FU_LSU   = 3;
  localparam int FU_HILO  = 4;
  localparam int FU_ALU2  = 5;
  localparam int FU_ALU3  = 6;

  localparam int REG_HILO = 32;

  typedef struct packed {
    logic [FU_W-1:0]   fu;
    logic [RIDX_W-1:0] reg1;
    logic              r1_val;
    logic [RIDX_W-1:0] reg2;
    logic              r2_val;
    logic [RIDX_W-1:0] reg3;
    logic              rf_we;
  } sb_fields_t;

endpackage

// File: rtl/sb_busy_table.sv
// Pending-destination bit vector for the scoreboard.
// One set port from issue, one clear port per FU writeback.
module sb_busy_table
  import sb_pkg::*;
#(
  parameter int NUM_FU = 7,
  parameter int REG_W  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_en,
  input  logic [REG_W-1:0]        set_reg,
  input  logic [NUM_FU-1:0]       clr_en,
  input  logic [NUM_FU*REG_W-1:0] clr_reg,
  input  logic [REG_W-1:0]        rd_reg1,
  input  logic [REG_W-1:0]        rd_reg2,
  input  logic [REG_W-1:0]        rd_reg3,
  output logic                    rd_busy1,
  output logic                    rd_busy2,
  output logic                    rd_busy3
);

  localparam int NREG = 1 << REG_W;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  // Set is applied after clears so it wins on a collision.
  always_comb begin
    pend_nxt = pend;
    for (int k = 0; k < NUM_FU; k++) begin
      if (clr_en[k]) begin
        pend_nxt[clr_reg[k*REG_W +: REG_W]] = 1'b0;
      end
    end
    if (set_en) begin
      pend_nxt[set_reg] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  assign rd_busy1 = pend[rd_reg1];
  assign rd_busy2 = pend[rd_reg2];
  assign rd_busy3 = pend[rd_reg3];

endmodule

// File: rtl/sb_issue_ctrl.sv
// Scoreboard issue controller: one-entry holding register that
// dispatches to an FU once RAW, WAW and structural hazards clear.
module sb_issue_ctrl
  import sb_pkg::*;
#(
  parameter int NUM_FU  = 7,
  parameter int INFO_WD = 137,
  parameter int REG_W   = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [INFO_WD-1:0]      in_info,
  output logic                    in_ready,
  input  logic                    flush,
  input  logic [NUM_FU-1:0]       fu_busy,
  output logic [NUM_FU-1:0]       issue_valid,
  output logic [INFO_WD-1:0]      issue_info,
  input  logic [NUM_FU-1:0]       wb_valid,
  input  logic [NUM_FU-1:0]       wb_we,
  input  logic [NUM_FU*REG_W-1:0] wb_reg,
  output logic [31:0]             stall_cnt
);

  logic               hold_valid;
  logic [INFO_WD-1:0] hold_info;
  logic [NUM_FU-1:0]  fu_pend;

  sb_fields_t f;
  logic       fu_ok;
  logic       fu_blk;
  logic       busy1;
  logic       busy2;
  logic       busy3;
  logic       haz;
  logic       go;
  logic       accept;

  assign f.fu     = hold_info[FU_LSB +: FU_W];
  assign f.reg1   = hold_info[REG1_LSB +: RIDX_W];
  assign f.r1_val = hold_info[R1V];
  assign f.reg2   = hold_info[REG2_LSB +: RIDX_W];
  assign f.r2_val = hold_info[R2V];
  assign f.reg3   = hold_info[REG3_LSB +: RIDX_W];
  assign f.rf_we  = hold_info[RFWE];

  sb_busy_table #(
    .NUM_FU (NUM_FU),
    .REG_W  (REG_W)
  ) u_busy (
    .clk      (clk),
    .reset    (reset),
    .set_en   (go & f.rf_we & (f.reg3 != '0)),
    .set_reg  (f.reg3),
    .clr_en   (wb_valid & wb_we),
    .clr_reg  (wb_reg),
    .rd_reg1  (f.reg1),
    .rd_reg2  (f.reg2),
    .rd_reg3  (f.reg3),
    .rd_busy1 (busy1),
    .rd_busy2 (busy2),
    .rd_busy3 (busy3)
  );

  // An out-of-range fu code is treated as permanently blocked.
  always_comb begin
    fu_ok  = 32'(f.fu) < NUM_FU;
    fu_blk = 1'b1;
    for (int k = 0; k < NUM_FU; k++) begin
      if (f.fu == FU_W'(k)) begin
        fu_blk = fu_busy[k] | fu_pend[k];
      end
    end
  end

  assign haz = (f.r1_val & busy1)
             | (f.r2_val & busy2)
             | (f.rf_we  & busy3);

  assign go = hold_valid & ~flush & fu_ok
            & ~fu_blk & ~haz;

  always_comb begin
    issue_valid = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      issue_valid[k] = go & (f.fu == FU_W'(k));
    end
  end

  assign issue_info = hold_info;
  assign in_ready   = ~flush & (~hold_valid | go);
  assign accept     = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_info  <= '0;
    end else begin
      if (flush) begin
        hold_valid <= 1'b0;
      end else if (accept) begin
        hold_valid <= 1'b1;
      end else if (go) begin
        hold_valid <= 1'b0;
      end
      if (accept) begin
        hold_info <= in_info;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fu_pend <= '0;
    end else begin
      fu_pend <= (fu_pend & ~wb_valid) | issue_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (hold_valid & ~go & ~flush
                 & (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_sb_issue_ctrl.sv
// Bench for sb_issue_ctrl: directed hazard scenarios plus random
// traffic, checked every cycle against an in-flight-op model.
module tb_sb_issue_ctrl;

  localparam int NF = 7;
  localparam int IW = 137;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [IW-1:0]   in_info;
  logic            in_ready;
  logic            flush;
  logic [NF-1:0]   fu_busy;
  logic [NF-1:0]   issue_valid;
  logic [IW-1:0]   issue_info;
  logic [NF-1:0]   wb_valid;
  logic [NF-1:0]   wb_we;
  logic [NF*6-1:0] wb_reg;
  logic [31:0]     stall_cnt;

  sb_issue_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_info     (in_info),
    .in_ready    (in_ready),
    .flush       (flush),
    .fu_busy     (fu_busy),
    .issue_valid (issue_valid),
    .issue_info  (issue_info),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_reg      (wb_reg),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  // Model: the held record plus, per FU, the op it has in flight.
  bit            m_hold;
  logic [IW-1:0] m_info;
  bit            m_inflt [NF];
  bit            m_wr    [NF];
  int            m_dst   [NF];
  logic [31:0]   m_stall;

  logic [NF-1:0] obs_iv;
  logic          obs_rdy;

  task automatic chk(string tag, logic [IW-1:0] got,
                     logic [IW-1:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit reg_pending(int r);
    if (r == 0) return 1'b0;
    for (int k = 0; k < NF; k++)
      if (m_inflt[k] && m_wr[k] && m_dst[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_pend();
    logic [63:0] p;
    p = '0;
    for (int r = 0; r < 64; r++) p[r] = reg_pending(r);
    return p;
  endfunction

  function automatic logic [NF-1:0] model_fupend();
    logic [NF-1:0] p;
    for (int k = 0; k < NF; k++) p[k] = m_inflt[k];
    return p;
  endfunction

  function automatic bit can_go();
    int fu;
    if (!m_hold || flush) return 1'b0;
    fu = int'(m_info[91:89]);
    if (fu >= NF) return 1'b0;
    if (fu_busy[fu] || m_inflt[fu]) return 1'b0;
    if (m_info[82] && reg_pending(int'(m_info[88:83]))) return 1'b0;
    if (m_info[74] && reg_pending(int'(m_info[80:75]))) return 1'b0;
    if (m_info[66] && reg_pending(int'(m_info[72:67]))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [IW-1:0] mk(int fu, int r1, bit v1,
                                       int r2, bit v2, int r3, bit we);
    logic [IW-1:0] x;
    for (int i = 0; i < IW; i++) x[i] = 1'($urandom_range(0, 1));
    x[91:89] = 3'(fu);
    x[88:83] = 6'(r1);
    x[82]    = v1;
    x[80:75] = 6'(r2);
    x[74]    = v2;
    x[72:67] = 6'(r3);
    x[66]    = we;
    return x;
  endfunction

  function automatic int rr();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 3;
      4: return 32;
      default: return int'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    in_info  = '0;
    flush    = 1'b0;
    fu_busy  = '0;
    wb_valid = '0;
    wb_we    = '0;
    wb_reg   = '0;
  endtask

  task automatic wb_fu(int k);
    wb_valid[k]       = 1'b1;
    wb_we[k]          = m_wr[k];
    wb_reg[k*6 +: 6]  = 6'(m_dst[k]);
  endtask

  task automatic send(logic [IW-1:0] rec);
    idle();
    in_valid = 1'b1;
    in_info  = rec;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #1;
    m_hold  = 1'b0;
    m_info  = '0;
    m_stall = '0;
    for (int k = 0; k < NF; k++) begin
      m_inflt[k] = 1'b0;
      m_wr[k]    = 1'b0;
      m_dst[k]   = 0;
    end
    chk("rst_in_ready", IW'(in_ready), IW'(1));
    chk("rst_issue_valid", IW'(issue_valid), '0);
    chk("rst_stall_cnt", IW'(stall_cnt), '0);
    chk("rst_pend", IW'(dut.u_busy.pend), '0);
    chk("rst_fu_pend", IW'(dut.fu_pend), '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Inputs are already driven; check, clock once, advance the model.
  task automatic step();
    bit            g;
    bit            rdy;
    bit            acc;
    int            fu;
    int            d;
    logic [NF-1:0] exp_iv;
    #1;
    g      = can_go();
    fu     = int'(m_info[91:89]);
    exp_iv = '0;
    if (g) exp_iv[fu] = 1'b1;
    rdy = !flush && (!m_hold || g);
    chk("issue_valid", IW'(issue_valid), IW'(exp_iv));
    chk("in_ready", IW'(in_ready), IW'(rdy));
    chk("stall_cnt", IW'(stall_cnt), IW'(m_stall));
    chk("pend", IW'(dut.u_busy.pend), IW'(model_pend()));
    chk("fu_pend", IW'(dut.fu_pend), IW'(model_fupend()));
    if (m_hold) chk("issue_info", issue_info, m_info);
    obs_iv  = issue_valid;
    obs_rdy = in_ready;
    if (in_valid)
      assert (in_info[91:89] < 3'd7)
        else $error("FAIL illegal_fu got=%0d", in_info[91:89]);
    if (g && m_info[66] && m_info[72:67] != 6'd0)
      for (int k = 0; k < NF; k++)
        assert (!(wb_valid[k] && wb_we[k]
                  && wb_reg[k*6 +: 6] == m_info[72:67]))
          else $error("FAIL set_clr_collision reg=%0d",
                      m_info[72:67]);
    @(posedge clk);
    acc = in_valid && rdy;
    for (int k = 0; k < NF; k++)
      if (wb_valid[k]) m_inflt[k] = 1'b0;
    if (g) begin
      d           = int'(m_info[72:67]);
      m_inflt[fu] = 1'b1;
      m_wr[fu]    = m_info[66] && d != 0;
      m_dst[fu]   = d;
    end
    if (m_hold && !g && !flush && m_stall != 32'hFFFF_FFFF)
      m_stall = m_stall + 32'd1;
    if (flush) m_hold = 1'b0;
    else if (acc) begin
      m_hold = 1'b1;
      m_info = in_info;
    end else if (g) m_hold = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    bit busy;
    busy = 1'b1;
    for (int c = 0; c < 30 && busy; c++) begin
      idle();
      for (int k = 0; k < NF; k++) if (m_inflt[k]) wb_fu(k);
      step();
      busy = m_hold;
      for (int k = 0; k < NF; k++) busy |= m_inflt[k];
    end
    chk("drain_timeout", IW'(busy), '0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    do_reset();

    // RAW on r3, woken one cycle after the writeback
    send(mk(0, 1, 1, 2, 1, 3, 1)); step();
    send(mk(1, 3, 1, 4, 1, 5, 1)); step();
    chk("raw_first", IW'(obs_iv), IW'(7'b0000001));
    repeat (3) begin
      idle(); step();
      chk("raw_hold", IW'(obs_iv), '0);
    end
    idle(); wb_fu(0); step();
    chk("raw_nobypass", IW'(obs_iv), '0);
    idle(); step();
    chk("raw_wake", IW'(obs_iv), IW'(7'b0000010));
    drain();

    // Structural on the LSU, also gated by fu_busy
    send(mk(3, 4, 1, 0, 0, 2, 1)); step();
    send(mk(3, 4, 1, 0, 0, 6, 1)); step();
    chk("lsu_first", IW'(obs_iv), IW'(7'b0001000));
    idle(); fu_busy[3] = 1'b1; step();
    chk("lsu_hold", IW'(obs_iv), '0);
    idle(); fu_busy[3] = 1'b1; wb_fu(3); step();
    chk("lsu_busy_wb", IW'(obs_iv), '0);
    idle(); fu_busy[3] = 1'b1; step();
    chk("lsu_busy", IW'(obs_iv), '0);
    idle(); step();
    chk("lsu_release", IW'(obs_iv), IW'(7'b0001000));
    drain();

    // HI/LO producer then mfhi
    send(mk(4, 1, 1, 2, 1, 32, 1)); step();
    send(mk(4, 0, 0, 32, 1, 7, 1)); step();
    chk("hilo_first", IW'(obs_iv), IW'(7'b0010000));
    idle(); step();
    chk("hilo_hold", IW'(obs_iv), '0);
    idle(); wb_fu(4); step();
    chk("hilo_nobypass", IW'(obs_iv), '0);
    idle(); step();
    chk("hilo_wake", IW'(obs_iv), IW'(7'b0010000));
    drain();

    // Flush a blocked record; pend[3] survives until its writeback
    send(mk(0, 1, 1, 2, 1, 3, 1)); step();
    send(mk(1, 3, 1, 0, 0, 8, 1)); step();
    idle(); step();
    chk("flush_pre", IW'(obs_iv), '0);
    idle(); flush = 1'b1; step();
    chk("flush_ready", IW'(obs_rdy), '0);
    chk("flush_noissue", IW'(obs_iv), '0);
    chk("flush_hold", IW'(dut.hold_valid), '0);
    chk("flush_pend3", IW'(dut.u_busy.pend[3]), IW'(1));
    idle(); wb_fu(0); step();
    send(mk(1, 3, 1, 3, 1, 9, 1)); step();
    idle(); step();
    chk("flush_reader", IW'(obs_iv), IW'(7'b0000010));
    drain();

    // r0 is never pending: back-to-back issue
    send(mk(0, 1, 1, 2, 1, 0, 1)); step();
    send(mk(1, 0, 1, 0, 1, 1, 1)); step();
    chk("r0_first", IW'(obs_iv), IW'(7'b0000001));
    chk("r0_refill", IW'(obs_rdy), IW'(1));
    idle(); step();
    chk("r0_second", IW'(obs_iv), IW'(7'b0000010));
    drain();

    // Mid-run reset with work in flight
    send(mk(2, 0, 0, 0, 0, 5, 1)); step();
    send(mk(2, 5, 1, 0, 0, 6, 1)); step();
    do_reset();

    for (int c = 0; c < 4000; c++) begin
      idle();
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      in_valid = ($urandom_range(0, 2) != 0);
      in_info  = mk(int'($urandom_range(0, 6)),
                    rr(), 1'($urandom_range(0, 1)),
                    rr(), 1'($urandom_range(0, 1)),
                    rr(), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < NF; k++) begin
        fu_busy[k] = ($urandom_range(0, 3) == 0);
        if (m_inflt[k] && $urandom_range(0, 2) == 0) wb_fu(k);
      end
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
